prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: BASE_ADDR, default 8'h00, first memory address written by a load.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle request to begin a load; sampled only in IDLE (and ERR when CHECKSUM_EN).
REQ-005 in_valid  in  1  source has a byte on in_data.
REQ-006 in_data  in  8  stream byte.
REQ-007 in_ready  out  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready.
REQ-008 mem_addr  out  8  write address to instruction memory port.
REQ-009 mem_data  out  8  write data to instruction memory port.
REQ-010 mem_wren  out  1  one-cycle write strobe.
REQ-011 cpu_hold  out  1  holds the processor in reset while high.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 done  out  1  one-cycle pulse on successful load completion.
REQ-014 error  out  1  checksum mismatch flag.

Function
REQ-015 The loader SHALL implement the states IDLE, HDR, DATA, CHK, DONE and ERR, all registered.
REQ-016 IDLE: in_ready=0, cpu_hold=0; start=1 -> HDR.
REQ-017 HDR: in_ready=1, cpu_hold=1; on transfer, latch count = in_data (8'h00 means 256), clear sum, set addr=BASE_ADDR -> DATA.
REQ-018 DATA: in_ready=1; on each transfer, the cycle after acceptance mem_wren=1, mem_addr=addr, mem_data=byte; addr increments mod 256; remaining decrements.
REQ-019 Write latency SHALL be exactly one cycle from transfer to the mem_wren pulse; back-to-back transfers SHALL produce back-to-back write pulses.
REQ-020 On the transfer of the last byte, DATA -> CHK (CHECKSUM_EN) or DONE (otherwise); the last write pulse occurs in the first cycle of the next state.
REQ-021 Cycles with in_valid=0 SHALL NOT change state, counters or memory outputs; mem_wren=0.
REQ-022 Address arithmetic SHALL wrap: BASE_ADDR=8'hFE, count=3 writes FE, FF, 00.
REQ-023 CHK: in_ready=1; on transfer, compare in_data with the mod-256 sum of all data bytes; match -> DONE, mismatch -> ERR.
REQ-024 DONE: in_ready=0, done=1 and cpu_hold=1 for exactly one cycle -> IDLE; cpu_hold falls on entry to IDLE.
REQ-025 ERR: in_ready=0, error=1, cpu_hold=1, held until reset or start; start in ERR -> HDR with error cleared.
REQ-026 start outside IDLE/ERR SHALL be ignored.
REQ-027 mem_wren SHALL be 0 in every cycle without a preceding DATA transfer; in_ready SHALL be a registered function of state only.

Reset
REQ-028 Reset SHALL force state IDLE and the outputs in_ready=0, mem_wren=0, mem_addr=8'h00, mem_data=8'h00, cpu_hold=0, busy=0, done=0, error=0, independent of clock.
REQ-029 Reset mid-load SHALL abort immediately; bytes already written remain in memory; no further write pulse occurs.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN defined: CHK and ERR states, the sum accumulator and error output are active per REQ-023/REQ-025.
REQ-031 Macro undefined: CHK and ERR do not exist, DATA -> DONE after the last byte, error is tied to 0, and no checksum byte is consumed.

Verification
REQ-032 start, stream 03,0A,1B,2C (no checksum build) -> writes 00:0A, 01:1B, 02:2C on consecutive cycles, done pulse once, cpu_hold high from HDR through DONE.
REQ-033 CHECKSUM_EN, stream 02,10,20,30 -> writes 00:10, 01:20, done=1, error=0; stream 02,10,20,31 -> ERR, error=1, cpu_hold=1 until start.
REQ-034 BASE_ADDR=8'hFE, stream 03,AA,BB,CC -> writes FE:AA, FF:BB, 00:CC.
REQ-035 count 00 followed by 256 bytes with random in_valid gaps -> exactly 256 write pulses, addresses 00..FF, no write during gaps.
REQ-036 Assert reset after the 2nd data byte of a 5-byte load -> all outputs at reset values within the same cycle, no 3rd write, next start loads normally.
REQ-037 start pulsed during DATA -> no effect on count, address or state.

Source files
------------

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input, instruction-memory write port and status of the program loader
interface prog_loader_if;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_wren;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;
    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_addr, mem_data, mem_wren, cpu_hold, busy, done, error
    );
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_addr, mem_data, mem_wren, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed byte stream into instruction memory while holding the CPU in reset;
// defining PROG_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte and the ERR state.
module prog_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input logic         clock,
    input logic         reset,
    prog_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, HDR, DATA, DONE
`ifdef PROG_LOADER_CHECKSUM_EN
        , CHK, ERR
`endif
    } state_t;

    state_t     state, next;
    logic [8:0] remaining;
    logic [7:0] addr;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next         = state;
        bus.in_ready = 1'b0;
        bus.done     = 1'b0;
        bus.error    = 1'b0;
        case (state)
            IDLE: next = bus.start ? HDR : IDLE;
            HDR: begin
                bus.in_ready = 1'b1;
                next         = bus.in_valid ? DATA : HDR;
            end
            DATA: begin
                bus.in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                next = (bus.in_valid && remaining == 9'd1) ? CHK : DATA;
`else
                next = (bus.in_valid && remaining == 9'd1) ? DONE : DATA;
`endif
            end
            DONE: begin
                bus.done = 1'b1;
                next     = IDLE;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                bus.in_ready = 1'b1;
                next         = !bus.in_valid ? CHK : (bus.in_data == sum) ? DONE : ERR;
            end
            ERR: begin
                bus.error = 1'b1;
                next      = bus.start ? HDR : ERR;
            end
`endif
            default: next = IDLE;
        endcase
    end

    assign bus.cpu_hold = state != IDLE;
    assign bus.busy     = state != IDLE;

    // Write port is registered so every accepted data byte appears exactly one cycle later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining    <= 9'd0;
            addr         <= 8'h00;
            bus.mem_wren <= 1'b0;
            bus.mem_addr <= 8'h00;
            bus.mem_data <= 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum          <= 8'h00;
`endif
        end else begin
            bus.mem_wren <= state == DATA && bus.in_valid;
            if (state == HDR && bus.in_valid) begin
                remaining <= {bus.in_data == 8'h00, bus.in_data};
                addr      <= BASE_ADDR;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum       <= 8'h00;
`endif
            end
            if (state == DATA && bus.in_valid) begin
                bus.mem_addr <= addr;
                bus.mem_data <= bus.in_data;
                addr         <= addr + 8'd1;
                remaining    <= remaining - 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum          <= sum + bus.in_data;
`endif
            end
        end
    end
endmodule
